mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS CPU. Sequences fetch, decode, execute,

---
 rtl/mips_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB, with a
//   HALT state entered when an instruction or data memory acknowledge never
//   arrives within TIMEOUT_CYC waiting cycles.
//   Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an illegal
//   instruction halts the controller. When it is undefined, an illegal
//   instruction retires as a NOP.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 15   // legal range 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_load,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Last count value at which a missing ack still leaves room to wait.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic       r_halted;

    logic       w_is_r;
    logic       w_is_j;
    logic       w_is_beq;
    logic       w_is_addi;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_r_legal;
    logic       w_legal;
    logic [2:0] w_alu_op;
    logic       w_alu_src;
    logic       w_waiting;
    logic       w_ack;
    logic       w_timeout;

    // Instruction class decode from the IR fields
    always_comb begin
        w_is_r    = (opcode == OP_RTYPE);
        w_is_j    = (opcode == OP_J);
        w_is_beq  = (opcode == OP_BEQ);
        w_is_addi = (opcode == OP_ADDI);
        w_is_lw   = (opcode == OP_LW);
        w_is_sw   = (opcode == OP_SW);
        w_r_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
        w_legal   = (w_is_r && w_r_legal) || w_is_addi || w_is_lw || w_is_sw || w_is_beq;
    end

    // ALU operation and operand select for the decoded instruction
    always_comb begin
        w_alu_op  = ALU_AND;
        w_alu_src = 1'b0;
        if (w_is_r) begin
            case (funct)
                FN_ADD:  w_alu_op = ALU_ADD;
                FN_SUB:  w_alu_op = ALU_SUB;
                FN_AND:  w_alu_op = ALU_AND;
                FN_OR:   w_alu_op = ALU_OR;
                FN_SLT:  w_alu_op = ALU_SLT;
                default: w_alu_op = ALU_AND;
            endcase
        end else if (w_is_addi || w_is_lw || w_is_sw) begin
            w_alu_op  = ALU_ADD;
            w_alu_src = 1'b1;
        end else if (w_is_beq) begin
            w_alu_op = ALU_SUB;
        end
    end

    // Memory handshake wait tracking: an ack in the last allowed cycle wins
    always_comb begin
        w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
        w_ack     = (r_state == ST_FETCH) ? imem_ack : dmem_ack;
        w_timeout = w_waiting && !w_ack && (r_wait == WAIT_LAST);
    end

    // Next-state and control outputs; everything held low during reset
    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src    = 1'b0;
        alu_op     = ALU_AND;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'b00;
                        w_next   = ST_DECODE;
                    end else if (w_timeout) begin
                        w_next = ST_HALT;
                    end
                end
                ST_DECODE: begin
                    if (w_is_j) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        w_next   = ST_FETCH;
                    end else if (w_legal) begin
                        w_next = ST_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        w_next = ST_HALT;
`else
                        w_next = ST_FETCH;
`endif
                    end
                end
                ST_EXEC: begin
                    alu_op  = w_alu_op;
                    alu_src = w_alu_src;
                    if (w_is_beq) begin
                        if (alu_zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                        w_next = ST_FETCH;
                    end else if (w_is_lw || w_is_sw) begin
                        w_next = ST_MEM;
                    end else if (w_is_r || w_is_addi) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end
                ST_MEM: begin
                    alu_op   = w_alu_op;
                    alu_src  = w_alu_src;
                    dmem_req = 1'b1;
                    dmem_we  = w_is_sw;
                    if (dmem_ack) begin
                        w_next = w_is_lw ? ST_WB : ST_FETCH;
                    end else if (w_timeout) begin
                        w_next = ST_HALT;
                    end
                end
                ST_WB: begin
                    alu_op     = w_alu_op;
                    alu_src    = w_alu_src;
                    reg_write  = 1'b1;
                    reg_dst    = w_is_r;
                    mem_to_reg = w_is_lw;
                    w_next     = ST_FETCH;
                end
                ST_HALT: begin
                    w_next = ST_HALT;
                end
                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

    // State, wait counter and sticky halt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_wait   <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= r_halted || (w_next == ST_HALT);
            // Any state change (entry into FETCH/MEM included) restarts the count.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting && !w_ack) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign halted    = r_halted && !reset;
    assign state_dbg = reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed and randomized instruction streams for mips_multicycle_ctrl.
//   Expected per-cycle behaviour is produced as a trace of cycles per
//   instruction class, following the architectural sequencing rules.
module tb_mips_multicycle_ctrl;

    localparam int K_R    = 0;
    localparam int K_ADDI = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_BEQ  = 4;
    localparam int K_J    = 5;
    localparam int K_ILL  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_load, pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, halted;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted),
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_load;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src;
        bit         chk_alu;
        logic       iack;
        logic       dack;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
    } step_t;

    step_t q[$];
    logic [5:0] rfun[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    function automatic ctl_t obs_ctl();
        ctl_t o;
        o = '{state_dbg, imem_req, dmem_req, dmem_we, ir_load, pc_write,
              reg_write, reg_dst, mem_to_reg, halted};
        return o;
    endfunction

    // ALU code required for each instruction class (R-type by funct)
    function automatic logic [2:0] exp_alu(input int k, input logic [5:0] fn);
        if (k == K_R) begin
            if (fn == 6'h20) return 3'b010;
            if (fn == 6'h22) return 3'b110;
            if (fn == 6'h25) return 3'b001;
            if (fn == 6'h2A) return 3'b111;
            return 3'b000;
        end
        if (k == K_BEQ) return 3'b110;
        return 3'b010;
    endfunction

    function automatic step_t mk(input logic [2:0] st, input logic [5:0] op,
                                 input logic [5:0] fn, input logic zero);
        step_t s;
        s.c       = '0;
        s.c.st    = st;
        s.pc_src  = 2'b00;
        s.alu_op  = 3'b000;
        s.alu_src = 1'b0;
        s.chk_alu = 1'b0;
        s.iack    = 1'b0;
        s.dack    = 1'b0;
        s.op      = op;
        s.fn      = fn;
        s.zero    = zero;
        return s;
    endfunction

    // Expected cycle trace of one instruction, appended to q
    task automatic build(input int k, input logic [5:0] op, input logic [5:0] fn,
                         input logic zero, input int iw, input int dw, output bit trapped);
        step_t s;
        logic  imm_op;
        trapped = 1'b0;
        imm_op  = (k == K_ADDI) || (k == K_LW) || (k == K_SW);
        for (int i = 0; i < iw; i++) begin
            s = mk(3'd0, op, fn, zero);
            s.c.imem_req = 1'b1;
            q.push_back(s);
        end
        s = mk(3'd0, op, fn, zero);
        s.c.imem_req = 1'b1;
        s.iack       = 1'b1;
        s.c.ir_load  = 1'b1;
        s.c.pc_write = 1'b1;
        s.pc_src     = 2'b00;
        q.push_back(s);
        s = mk(3'd1, op, fn, zero);
        if (k == K_J) begin
            s.c.pc_write = 1'b1;
            s.pc_src     = 2'b10;
            q.push_back(s);
            return;
        end
        q.push_back(s);
        if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 2; i++) begin
                s = mk(3'd5, op, fn, zero);
                s.c.halted = 1'b1;
                q.push_back(s);
            end
            trapped = 1'b1;
`endif
            return;
        end
        s = mk(3'd2, op, fn, zero);
        s.chk_alu = 1'b1;
        s.alu_op  = exp_alu(k, fn);
        s.alu_src = imm_op;
        if (k == K_BEQ) begin
            s.c.pc_write = zero;
            s.pc_src     = 2'b01;
            q.push_back(s);
            return;
        end
        q.push_back(s);
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= dw; i++) begin
                s = mk(3'd3, op, fn, zero);
                s.c.dmem_req = 1'b1;
                s.c.dmem_we  = (k == K_SW);
                s.dack       = (i == dw);
                q.push_back(s);
            end
            if (k == K_SW) return;
        end
        s = mk(3'd4, op, fn, zero);
        s.c.reg_write  = 1'b1;
        s.c.reg_dst    = (k == K_R);
        s.c.mem_to_reg = (k == K_LW);
        s.chk_alu      = 1'b1;
        s.alu_op       = exp_alu(k, fn);
        s.alu_src      = imm_op;
        q.push_back(s);
    endtask

    task automatic check_step(input step_t s, input string tag);
        ctl_t o;
        o = obs_ctl();
        checks++;
        assert (o === s.c) else begin
            errors++;
            $error("FAIL %s ctl: observed %h expected %h", tag, o, s.c);
        end
        if (s.c.pc_write) begin
            checks++;
            assert (pc_src === s.pc_src) else begin
                errors++;
                $error("FAIL %s pc_src: observed %b expected %b", tag, pc_src, s.pc_src);
            end
        end
        if (s.chk_alu) begin
            checks++;
            assert ({alu_op, alu_src} === {s.alu_op, s.alu_src}) else begin
                errors++;
                $error("FAIL %s alu: observed %b/%b expected %b/%b",
                       tag, alu_op, alu_src, s.alu_op, s.alu_src);
            end
        end
    endtask

    // Play up to n queued cycles (n<0: all), then drop the remainder
    task automatic run_q(input string tag, input int n);
        step_t s;
        int    done = 0;
        while (q.size() > 0 && (n < 0 || done < n)) begin
            s = q.pop_front();
            @(negedge clk);
            reset    = 1'b0;
            opcode   = s.op;
            funct    = s.fn;
            alu_zero = s.zero;
            imem_ack = s.iack;
            dmem_ack = s.dack;
            #1;
            check_step(s, tag);
            done++;
        end
        q.delete();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = 1'b1;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'b1;
            #1;
            checks++;
            assert ({state_dbg, halted, imem_req, dmem_req, dmem_we, ir_load, pc_write,
                     pc_src, alu_src, alu_op, reg_write, reg_dst, mem_to_reg} === 20'h0) else begin
                errors++;
                $error("FAIL reset_zero: observed state %0d halted %b reg_write %b pc_write %b imem_req %b expected all 0",
                       state_dbg, halted, reg_write, pc_write, imem_req);
            end
        end
    endtask

    // Waiting cycles that never see an ack, followed by HALT
    task automatic timeout_trace(input bit in_mem);
        step_t s;
        bit    t;
        if (in_mem) begin
            build(K_LW, 6'h23, 6'h04, 1'b0, 0, 0, t);
            void'(q.pop_back());
            void'(q.pop_back());
        end
        for (int i = 0; i < 15; i++) begin
            s = mk(in_mem ? 3'd3 : 3'd0, 6'h23, 6'h04, 1'b0);
            s.c.imem_req = !in_mem;
            s.c.dmem_req = in_mem;
            q.push_back(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = mk(3'd5, 6'h23, 6'h04, 1'b0);
            s.c.halted = 1'b1;
            q.push_back(s);
        end
    endtask

    task automatic pick_illegal(output logic [5:0] op, output logic [5:0] fn);
        if ($urandom_range(0, 1) == 0) begin
            op = 6'h00;
            do fn = 6'($urandom); while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                          fn == 6'h25 || fn == 6'h2A);
        end else begin
            do op = 6'($urandom); while (op == 6'h00 || op == 6'h02 || op == 6'h04 ||
                                          op == 6'h08 || op == 6'h23 || op == 6'h2B);
            fn = 6'($urandom);
        end
    endtask

    initial begin
        bit         t;
        int         k;
        logic [5:0] op, fn;
        logic [5:0] ops[6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};

        do_reset(2);

        build(K_R, 6'h00, 6'h20, 1'b0, 0, 0, t);  run_q("add", -1);
        build(K_R, 6'h00, 6'h2A, 1'b0, 0, 0, t);  run_q("slt", -1);
        build(K_LW, 6'h23, 6'h04, 1'b0, 0, 2, t); run_q("lw_wait2", -1);
        build(K_SW, 6'h2B, 6'h04, 1'b0, 1, 0, t); run_q("sw", -1);
        build(K_BEQ, 6'h04, 6'h03, 1'b1, 0, 0, t); run_q("beq_taken", -1);
        build(K_BEQ, 6'h04, 6'h03, 1'b0, 0, 0, t); run_q("beq_not", -1);
        build(K_J, 6'h02, 6'h00, 1'b0, 0, 0, t);  run_q("j", -1);
        build(K_ADDI, 6'h08, 6'h11, 1'b0, 14, 0, t); run_q("ack_last", -1);
        build(K_ILL, 6'h3F, 6'h00, 1'b0, 0, 0, t); run_q("illegal3f", -1);
        if (t) do_reset(1);
        build(K_SW, 6'h2B, 6'h00, 1'b0, 0, 14, t); run_q("dmem_ack_last", -1);

        timeout_trace(1'b0); run_q("imem_timeout", -1);
        do_reset(2);
        timeout_trace(1'b1); run_q("dmem_timeout", -1);
        do_reset(1);

        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 6);
            if (k == K_ILL) begin
                pick_illegal(op, fn);
            end else begin
                op = ops[k];
                fn = (k == K_R) ? rfun[$urandom_range(0, 4)] : 6'($urandom);
            end
            build(k, op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), t);
            run_q("random", -1);
            if (t) do_reset(1);
        end

        // Abort a load in MEM: reset must drop everything and restart in FETCH
        build(K_LW, 6'h23, 6'h04, 1'b0, 0, 3, t); run_q("lw_abort", 4);
        do_reset(1);
        build(K_ADDI, 6'h08, 6'h00, 1'b0, 0, 0, t); run_q("after_abort", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
